// File: rtl/tcm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tcm_port_arbiter
// Purpose  : Shares one single-port TCM SRAM among three requesters: core
//            instruction fetch (I), core load/store (D) and an external
//            loader/debug port (X). One access per cycle, fixed one-cycle
//            response latency. X has priority, I/D alternate round-robin, and
//            a burst guard stops X from starving the core indefinitely.
// Ports    : clk, rst_n (async, active low), ext_lock (X-only loader phase)
//            i_*  : fetch port (read only)   req/addr -> gnt/rvalid/rdata
//            d_*  : load/store port          req/we/wstrb/addr/wdata -> gnt/rvalid/rdata
//            x_*  : loader/debug port        same shape as d_*
//            sram_* : SRAM strobe, byte write enables, address, data in/out
// Revision : 1.0 - initial release
// ============================================================================
module tcm_port_arbiter #(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 32,
  parameter int MAX_EXT_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_lock,
  // Instruction fetch
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  // Load/store
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  // External loader/debug
  input  logic                  x_req,
  input  logic                  x_we,
  input  logic [DATA_W/8-1:0]   x_wstrb,
  input  logic [ADDR_W-1:0]     x_addr,
  input  logic [DATA_W-1:0]     x_wdata,
  output logic                  x_gnt,
  output logic                  x_rvalid,
  output logic [DATA_W-1:0]     x_rdata,
  // SRAM
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  localparam int                CNT_W       = $clog2(MAX_EXT_BURST + 1);
  localparam logic [CNT_W-1:0]  C_BURST_MAX = CNT_W'(MAX_EXT_BURST);

  typedef enum logic       {RR_I = 1'b0, RR_D = 1'b1} rr_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2, OWN_X = 2'd3} own_e;

  rr_e              rr_q, rr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  own_e             owner_q, owner_d;
  logic             owner_we_q, owner_we_d;

  logic w_id_req;
  logic w_pick_i;
  logic w_pick_d;
  logic w_guard;

  // Grant decode. Grants are also gated by rst_n so that nothing reaches the
  // SRAM while reset is held, even if requesters keep their req lines high.
  always_comb begin
    w_id_req = !ext_lock && (i_req || d_req);
    // A lone requester always wins; with both present rr_q breaks the tie.
    w_pick_i = i_req && (!d_req || (rr_q == RR_I));
    w_pick_d = d_req && (!i_req || (rr_q == RR_D));
    // Once X has taken MAX_EXT_BURST grants in a row over a waiting core,
    // the core gets the next slot.
    w_guard  = w_id_req && (burst_cnt_q == C_BURST_MAX);
    x_gnt    = rst_n && x_req && !w_guard;
    i_gnt    = rst_n && !ext_lock && !x_gnt && w_pick_i;
    d_gnt    = rst_n && !ext_lock && !x_gnt && w_pick_d;
  end

  // SRAM bus mux from whichever port holds the grant; all zero when idle.
  always_comb begin
    sram_en    = x_gnt || i_gnt || d_gnt;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (x_gnt) begin
      sram_we    = x_we ? x_wstrb : '0;
      sram_addr  = x_addr;
      sram_wdata = x_wdata;
    end else if (d_gnt) begin
      sram_we    = d_we ? d_wstrb : '0;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_addr  = i_addr;
    end
  end

  // Next-state: round-robin pointer, burst counter, response owner tag.
  always_comb begin
    rr_d = rr_q;
    if (i_gnt) begin
      rr_d = RR_D;
    end else if (d_gnt) begin
      rr_d = RR_I;
    end

    burst_cnt_d = burst_cnt_q;
    if (ext_lock || i_gnt || d_gnt || !(i_req || d_req)) begin
      burst_cnt_d = '0;
    end else if (x_gnt && (burst_cnt_q != C_BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end

    owner_d    = OWN_NONE;
    owner_we_d = 1'b0;
    if (x_gnt) begin
      owner_d    = OWN_X;
      owner_we_d = x_we;
    end else if (d_gnt) begin
      owner_d    = OWN_D;
      owner_we_d = d_we;
    end else if (i_gnt) begin
      owner_d    = OWN_I;
    end
  end

  // Async reset clears the owner tag, so a response due right after reset
  // asserts is simply never presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= RR_I;
      burst_cnt_q <= '0;
      owner_q     <= OWN_NONE;
      owner_we_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
      owner_we_q  <= owner_we_d;
    end
  end

  // Response steering: only the owning port sees rvalid and read data;
  // write acks return zero data.
  always_comb begin
    i_rvalid = (owner_q == OWN_I);
    d_rvalid = (owner_q == OWN_D);
    x_rvalid = (owner_q == OWN_X);
    i_rdata  = i_rvalid ? sram_rdata : '0;
    d_rdata  = (d_rvalid && !owner_we_q) ? sram_rdata : '0;
    x_rdata  = (x_rvalid && !owner_we_q) ? sram_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_tcm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcm_port_arbiter
// Purpose  : Directed, scoreboard-checked bench for tcm_port_arbiter. The
//            stimulus process checks grants and queues the expected response;
//            a separate monitor compares each response cycle. A behavioural
//            SRAM answers reads; unwritten words read as 0xC0DE_0000 | addr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcm_port_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int SW     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ext_lock;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [SW-1:0]     d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              x_req, x_we;
  logic [SW-1:0]     x_wstrb;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              x_gnt, x_rvalid;
  logic [DATA_W-1:0] x_rdata;
  logic              sram_en;
  logic [SW-1:0]     sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0]  port;   // {x,d,i}
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;
  exp_t sbq[$];

  tcm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_EXT_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .ext_lock(ext_lock),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .x_req(x_req), .x_we(x_we), .x_wstrb(x_wstrb), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    if (sram_en) begin
      logic [31:0] w;
      w = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : (32'hC0DE_0000 | 32'(sram_addr));
      sram_rdata <= w;
      for (int b = 0; b < SW; b++)
        if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
      mem[int'(sram_addr)] = w;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    logic [2:0]  rv;
    logic [95:0] act, expb;
    exp_t        e;
    rv  = {x_rvalid, d_rvalid, i_rvalid};
    act = {x_rdata, d_rdata, i_rdata};
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e    = sbq.pop_front();
      expb = '0;
      if (e.port[0]) expb[31:0]  = e.data;
      if (e.port[1]) expb[63:32] = e.data;
      if (e.port[2]) expb[95:64] = e.data;
      checks++;
      if (rv !== e.port || act !== expb) begin
        failures++;
        $display("FAIL rsp_%s: rvalid{x,d,i}=%b rdata{x,d,i}=%h, required rvalid=%b rdata=%h",
                 e.name, rv, act, e.port, expb);
      end
    end else if (rv !== 3'b000) begin
      checks++;
      failures++;
      $display("FAIL rsp_unexpected: rvalid{x,d,i}=%b at cycle %0d, required 000", rv, cyc);
    end
  end

  function automatic bit outs_zero();
    return ({i_gnt, d_gnt, x_gnt, i_rvalid, d_rvalid, x_rvalid, sram_en} == 7'b0) &&
           (i_rdata == '0) && (d_rdata == '0) && (x_rdata == '0) &&
           (sram_we == '0) && (sram_addr == '0) && (sram_wdata == '0);
  endfunction

  task automatic check_reset_outs(input string name);
    checks++;
    if (!outs_zero()) begin
      failures++;
      $display("FAIL %s: gnt{x,d,i}=%b rvalid{x,d,i}=%b sram_en=%b addr=%h, required all 0",
               name, {x_gnt, d_gnt, i_gnt}, {x_rvalid, d_rvalid, i_rvalid}, sram_en, sram_addr);
    end
  endtask

  // One cycle of stimulus: drive at posedge+1, check grants at negedge, queue
  // the expected response for the following cycle, return at next posedge+1.
  task automatic drv(input logic lock,
                     input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic dr, input logic dw, input logic [SW-1:0] ds,
                     input logic [ADDR_W-1:0] da, input logic [31:0] dd,
                     input logic xr, input logic xw, input logic [SW-1:0] xs,
                     input logic [ADDR_W-1:0] xa, input logic [31:0] xd,
                     input logic [2:0] eg, input logic [31:0] ed,
                     input bit push, input string name);
    exp_t e;
    ext_lock = lock;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_wstrb = ds; d_addr = da; d_wdata = dd;
    x_req = xr; x_we = xw; x_wstrb = xs; x_addr = xa; x_wdata = xd;
    @(negedge clk);
    checks++;
    if ({x_gnt, d_gnt, i_gnt} !== eg) begin
      failures++;
      $display("FAIL gnt_%s: gnt{x,d,i}=%b, required %b", name, {x_gnt, d_gnt, i_gnt}, eg);
    end
    if (push && eg != 3'b000) begin
      e.port = eg; e.data = ed; e.due = cyc + 1; e.name = name;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every requester active: nothing may leak out.
    rst_n = 1'b0; ext_lock = 1'b0;
    i_req = 1'b1; i_addr = 15'h0123;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 15'h0456; d_wdata = 32'hFFFF_FFFF;
    x_req = 1'b1; x_we = 1'b1; x_wstrb = 4'hF; x_addr = 15'h0789; x_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: loader phase, only X granted although I and D request.
    for (int n = 0; n < 4; n++)
      drv(1, 1, 15'h0100, 1, 0, 4'h0, 15'h0200, 32'h0,
          1, 1, 4'hF, 15'(n), 32'hA5A5_0000 + 32'(n), 3'b100, 32'h0, 1, $sformatf("lock_xwr%0d", n));
    drv(1, 1, 15'h0100, 1, 0, 4'h0, 15'h0200, 32'h0,
        1, 0, 4'h0, 15'h0002, 32'h0, 3'b100, 32'hA5A5_0002, 1, "lock_xrd2");

    // 2: I and D continuous, X idle: I,D,I,D from rr_ptr=I.
    for (int k = 0; k < 3; k++) begin
      drv(0, 1, 15'h0100 + 15'(k), 1, 0, 4'h0, 15'h0200 + 15'(k), 32'h0,
          0, 0, 4'h0, 15'h0, 32'h0, 3'b001, 32'hC0DE_0100 + 32'(k), 1, $sformatf("rr_i%0d", k));
      drv(0, 1, 15'h0101 + 15'(k), 1, 0, 4'h0, 15'h0200 + 15'(k), 32'h0,
          0, 0, 4'h0, 15'h0, 32'h0, 3'b010, 32'hC0DE_0200 + 32'(k), 1, $sformatf("rr_d%0d", k));
    end

    // 6: all three request, burst count below limit -> X only; then rr_ptr still I.
    drv(0, 1, 15'h0110, 1, 0, 4'h0, 15'h0210, 32'h0,
        1, 1, 4'hF, 15'h0300, 32'h0000_0001, 3'b100, 32'h0, 1, "all3_x");
    drv(0, 1, 15'h0110, 1, 0, 4'h0, 15'h0210, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b001, 32'hC0DE_0110, 1, "all3_rr_kept");

    // 3: X every cycle vs continuous D: 8 X, 1 D, 8 X, 1 D.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 8; n++)
        drv(0, 0, 15'h0, 1, 0, 4'h0, 15'h0500 + 15'(r), 32'h0,
            1, 1, 4'hF, 15'h0400 + 15'(r*8 + n), 32'(n), 3'b100, 32'h0, 1,
            $sformatf("burst_x%0d_%0d", r, n));
      drv(0, 0, 15'h0, 1, 0, 4'h0, 15'h0500 + 15'(r), 32'h0,
          1, 1, 4'hF, 15'h0410 + 15'(r), 32'h0, 3'b010, 32'hC0DE_0500 + 32'(r), 1,
          $sformatf("burst_guard_d%0d", r));
    end

    // 4: partial-strobe write over old data, then read back.
    drv(0, 0, 15'h0, 1, 1, 4'hF, 15'h0010, 32'h1234_5678,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b010, 32'h0, 1, "strb_wr_full");
    drv(0, 0, 15'h0, 1, 1, 4'b0011, 15'h0010, 32'hDEAD_BEEF,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b010, 32'h0, 1, "strb_wr_low");
    drv(0, 0, 15'h0, 1, 0, 4'h0, 15'h0010, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b010, 32'h1234_BEEF, 1, "strb_rd");

    // 5: reset asserted the cycle after an I grant drops its response.
    drv(0, 1, 15'h0120, 0, 0, 4'h0, 15'h0, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b001, 32'h0, 0, "pre_reset_i");
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; x_req = 1'b1; x_addr = 15'h0055;
    @(negedge clk);
    check_reset_outs("midrun_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(0, 1, 15'h0130, 1, 0, 4'h0, 15'h0230, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b001, 32'hC0DE_0130, 1, "post_reset_i_first");
    drv(0, 1, 15'h0131, 1, 0, 4'h0, 15'h0230, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b010, 32'hC0DE_0230, 1, "post_reset_d");

    // Idle tail: drain responses, nothing left outstanding.
    drv(0, 0, 15'h0, 0, 0, 4'h0, 15'h0, 32'h0,
        0, 0, 4'h0, 15'h0, 32'h0, 3'b000, 32'h0, 1, "idle");
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
